mmucfg_ctrl: RTL and testbench

- Parametrised multi-context MMU configuration controller; successor to the single-context flat MMU config signal set.
- Holds NUM_CTX configuration contexts: MMU enable, privilege, 64-bit mode, SMEM extension.
- Drives the active context's configuration to the MMU.
- Updates to the live context are applied only after in-flight translations drain. Updates to non-live contexts apply immediately.

---
 rtl/mmucfg_ctrl_if.sv | 28 ++
 rtl/mmucfg_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mmucfg_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mmucfg_ctrl_if.sv
// Config-write and translation handshake bundle for mmucfg_ctrl.
interface mmucfg_ctrl_if #(
  parameter int CTX_W  = 2,
  parameter int SMEM_W = 5
);
  logic              cfg_wr_valid;
  logic              cfg_wr_ready;
  logic [CTX_W-1:0]  cfg_wr_ctx;
  logic              cfg_wr_mmu_enable;
  logic              cfg_wr_priv;
  logic              cfg_wr_k1_64;
  logic [SMEM_W-1:0] cfg_wr_smem_ext;
  logic              xlat_req;
  logic              xlat_req_ready;
  logic              xlat_done;

  modport master (
    output cfg_wr_valid, cfg_wr_ctx, cfg_wr_mmu_enable, cfg_wr_priv,
           cfg_wr_k1_64, cfg_wr_smem_ext, xlat_req, xlat_done,
    input  cfg_wr_ready, xlat_req_ready
  );

  modport slave (
    input  cfg_wr_valid, cfg_wr_ctx, cfg_wr_mmu_enable, cfg_wr_priv,
           cfg_wr_k1_64, cfg_wr_smem_ext, xlat_req, xlat_done,
    output cfg_wr_ready, xlat_req_ready
  );
endinterface

// File: rtl/mmucfg_ctrl.sv
// Multi-context MMU configuration controller. Holds NUM_CTX config contexts,
// drives the live one to the MMU, and defers writes to the live context until
// all in-flight translations have retired.
module mmucfg_ctrl #(
  parameter int NUM_CTX      = 4,
  parameter int CTX_W        = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int SMEM_W       = 5,
  parameter int MAX_OUT      = 8,
  parameter int CNT_W        = $clog2(MAX_OUT + 1),
  parameter int DEBUG_BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CTX_W-1:0]  active_ctx,
  input  logic              processor_in_debug_m,
  mmucfg_ctrl_if.slave      bus,
  output logic              mmu_enable_m,
  output logic              priviledge_mode_m,
  output logic              k1_64_mode_m,
  output logic [SMEM_W-1:0] smem_ext_cfg_m,
  output logic              cfg_commit,
  output logic [CNT_W-1:0]  outstanding_cnt,
  output logic              underflow_err
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT} state_t;

  state_t r_state, w_state_nxt;

  logic              r_ctx_en   [NUM_CTX];
  logic              r_ctx_priv [NUM_CTX];
  logic              r_ctx_k64  [NUM_CTX];
  logic [SMEM_W-1:0] r_ctx_smem [NUM_CTX];

  logic              r_stg_en, r_stg_priv, r_stg_k64;
  logic [SMEM_W-1:0] r_stg_smem;

  logic [CTX_W-1:0]  r_live;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_commit, r_underflow;
  logic              r_en_m, r_priv_m, r_k64_m;
  logic [SMEM_W-1:0] r_smem_m;

  logic w_wr_ready, w_req_ready;
  logic w_wr_acc, w_wr_live, w_wr_other, w_wr_in_range;
  logic w_inc, w_dec, w_cnt_nz, w_underflow, w_switch, w_dbg_kill;

  // Handshake decode
  assign w_wr_acc      = bus.cfg_wr_valid & w_wr_ready;
  assign w_wr_in_range = (int'(bus.cfg_wr_ctx) < NUM_CTX);
  // A single-context controller always targets the live context.
  assign w_wr_live     = w_wr_acc & ((NUM_CTX == 1) | (bus.cfg_wr_ctx == r_live));
  assign w_wr_other    = w_wr_acc & ~w_wr_live & w_wr_in_range;
  assign w_inc         = bus.xlat_req & w_req_ready;
  assign w_cnt_nz      = (r_cnt != '0);
  // A retire at count 0 alongside a fresh issue pairs with that issue.
  assign w_dec         = bus.xlat_done & (w_cnt_nz | w_inc);
  assign w_underflow   = bus.xlat_done & ~w_cnt_nz & ~w_inc;
  assign w_switch      = (r_state == S_IDLE) & ~w_cnt_nz & ~w_inc & ~w_wr_acc &
                         (int'(active_ctx) < NUM_CTX);
  assign w_dbg_kill    = (DEBUG_BYPASS != 0) & processor_in_debug_m;

  // Next outstanding count after this cycle's issue/retire
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_inc && !w_dec)      w_cnt_nxt = r_cnt + CNT_W'(1);
    else if (!w_inc && w_dec) w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_wr_live) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_cnt_nxt == '0) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: both channels only accept while idle
  always_comb begin
    w_wr_ready  = (r_state == S_IDLE);
    w_req_ready = (r_state == S_IDLE) && (r_cnt < CNT_W'(MAX_OUT));
  end

  assign bus.cfg_wr_ready   = w_wr_ready;
  assign bus.xlat_req_ready = w_req_ready;

  // Context storage, staging, live index, counter and status
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CTX; i++) begin
        r_ctx_en[i]   <= 1'b0;
        r_ctx_priv[i] <= 1'b1;
        r_ctx_k64[i]  <= 1'b0;
        r_ctx_smem[i] <= '0;
      end
      r_stg_en    <= 1'b0;
      r_stg_priv  <= 1'b1;
      r_stg_k64   <= 1'b0;
      r_stg_smem  <= '0;
      r_live      <= '0;
      r_cnt       <= '0;
      r_commit    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_commit <= w_wr_other | (r_state == S_COMMIT);
      if (w_underflow) r_underflow <= 1'b1;
      if (w_switch)    r_live      <= active_ctx;
      if (w_wr_live) begin
        r_stg_en   <= bus.cfg_wr_mmu_enable;
        r_stg_priv <= bus.cfg_wr_priv;
        r_stg_k64  <= bus.cfg_wr_k1_64;
        r_stg_smem <= bus.cfg_wr_smem_ext;
      end
      if (w_wr_other) begin
        r_ctx_en[bus.cfg_wr_ctx]   <= bus.cfg_wr_mmu_enable;
        r_ctx_priv[bus.cfg_wr_ctx] <= bus.cfg_wr_priv;
        r_ctx_k64[bus.cfg_wr_ctx]  <= bus.cfg_wr_k1_64;
        r_ctx_smem[bus.cfg_wr_ctx] <= bus.cfg_wr_smem_ext;
      end else if (r_state == S_COMMIT) begin
        r_ctx_en[r_live]   <= r_stg_en;
        r_ctx_priv[r_live] <= r_stg_priv;
        r_ctx_k64[r_live]  <= r_stg_k64;
        r_ctx_smem[r_live] <= r_stg_smem;
      end
    end
  end

  // Registered live config towards the MMU, with debug enable override
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_en_m   <= 1'b0;
      r_priv_m <= 1'b1;
      r_k64_m  <= 1'b0;
      r_smem_m <= '0;
    end else begin
      r_en_m   <= r_ctx_en[r_live] & ~w_dbg_kill;
      r_priv_m <= r_ctx_priv[r_live];
      r_k64_m  <= r_ctx_k64[r_live];
      r_smem_m <= r_ctx_smem[r_live];
    end
  end

  assign mmu_enable_m      = r_en_m;
  assign priviledge_mode_m = r_priv_m;
  assign k1_64_mode_m      = r_k64_m;
  assign smem_ext_cfg_m    = r_smem_m;
  assign cfg_commit        = r_commit;
  assign outstanding_cnt   = r_cnt;
  assign underflow_err     = r_underflow;

endmodule

// File: tb/tb_mmucfg_ctrl.sv
// Directed bench for mmucfg_ctrl with hand-computed expectations.
module tb_mmucfg_ctrl;
  localparam int NUM_CTX = 4;
  localparam int CTX_W   = 2;
  localparam int SMEM_W  = 5;
  localparam int MAX_OUT = 8;
  localparam int CNT_W   = 4;

  logic              clock;
  logic              reset;
  logic [CTX_W-1:0]  active_ctx;
  logic              dbg;
  logic              en_m, priv_m, k64_m, commit, uflow;
  logic [SMEM_W-1:0] smem_m;
  logic [CNT_W-1:0]  cnt;

  int n_checks = 0;
  int n_errs   = 0;

  mmucfg_ctrl_if #(.CTX_W(CTX_W), .SMEM_W(SMEM_W)) bus ();

  mmucfg_ctrl #(
    .NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .SMEM_W(SMEM_W),
    .MAX_OUT(MAX_OUT), .CNT_W(CNT_W), .DEBUG_BYPASS(1)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .active_ctx           (active_ctx),
    .processor_in_debug_m (dbg),
    .bus                  (bus.slave),
    .mmu_enable_m         (en_m),
    .priviledge_mode_m    (priv_m),
    .k1_64_mode_m         (k64_m),
    .smem_ext_cfg_m       (smem_m),
    .cfg_commit           (commit),
    .outstanding_cnt      (cnt),
    .underflow_err        (uflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [CTX_W-1:0] c, input logic e, input logic p,
                    input logic k, input logic [SMEM_W-1:0] s);
    bus.cfg_wr_valid      = 1'b1;
    bus.cfg_wr_ctx        = c;
    bus.cfg_wr_mmu_enable = e;
    bus.cfg_wr_priv       = p;
    bus.cfg_wr_k1_64      = k;
    bus.cfg_wr_smem_ext   = s;
  endtask

  initial begin
    reset = 1'b0; active_ctx = '0; dbg = 1'b0;
    bus.cfg_wr_valid = 1'b0; bus.cfg_wr_ctx = '0; bus.cfg_wr_mmu_enable = 1'b0;
    bus.cfg_wr_priv = 1'b0; bus.cfg_wr_k1_64 = 1'b0; bus.cfg_wr_smem_ext = '0;
    bus.xlat_req = 1'b0; bus.xlat_done = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);

    // reset / idle state
    chk("rst_en",    32'(en_m), 0);
    chk("rst_priv",  32'(priv_m), 1);
    chk("rst_k64",   32'(k64_m), 0);
    chk("rst_smem",  32'(smem_m), 0);
    chk("rst_wrrdy", 32'(bus.cfg_wr_ready), 1);
    chk("rst_rqrdy", 32'(bus.xlat_req_ready), 1);
    chk("rst_cnt",   32'(cnt), 0);
    chk("rst_cmt",   32'(commit), 0);

    // non-live write with 3 outstanding
    bus.xlat_req = 1'b1; tick(3); bus.xlat_req = 1'b0;
    chk("cnt3", 32'(cnt), 3);
    wr(2'd2, 1'b1, 1'b0, 1'b1, 5'h13);
    chk("nl_wrrdy", 32'(bus.cfg_wr_ready), 1);
    tick(); bus.cfg_wr_valid = 1'b0;
    chk("nl_cmt", 32'(commit), 1);
    chk("nl_nostall", 32'(bus.cfg_wr_ready), 1);
    chk("nl_en_unch", 32'(en_m), 0);
    tick();
    chk("nl_cmt_off", 32'(commit), 0);
    chk("nl_priv_unch", 32'(priv_m), 1);
    active_ctx = 2'd2;
    bus.xlat_done = 1'b1; tick(3); bus.xlat_done = 1'b0;
    chk("sw_cnt0", 32'(cnt), 0);
    tick();
    chk("sw_lat_priv", 32'(priv_m), 1);
    tick();
    chk("sw_en",   32'(en_m), 1);
    chk("sw_priv", 32'(priv_m), 0);
    chk("sw_k64",  32'(k64_m), 1);
    chk("sw_smem", 32'(smem_m), 32'h13);
    active_ctx = 2'd0; tick(2);
    chk("back_en", 32'(en_m), 0);

    // live write drains 2 outstanding
    bus.xlat_req = 1'b1; tick(2); bus.xlat_req = 1'b0;
    wr(2'd0, 1'b1, 1'b1, 1'b0, 5'h00);
    tick(); bus.cfg_wr_valid = 1'b0;
    chk("dr_wrrdy", 32'(bus.cfg_wr_ready), 0);
    chk("dr_rqrdy", 32'(bus.xlat_req_ready), 0);
    bus.xlat_req = 1'b1; tick(); bus.xlat_req = 1'b0;
    chk("dr_req_ign", 32'(cnt), 2);
    bus.xlat_done = 1'b1; tick(2); bus.xlat_done = 1'b0;
    chk("cm_cnt", 32'(cnt), 0);
    chk("cm_wrrdy", 32'(bus.cfg_wr_ready), 0);
    chk("cm_cmt_pre", 32'(commit), 0);
    tick();
    chk("cm_cmt", 32'(commit), 1);
    chk("cm_en_pre", 32'(en_m), 0);
    chk("cm_idle", 32'(bus.cfg_wr_ready), 1);
    tick();
    chk("cm_en", 32'(en_m), 1);
    chk("cm_cmt_off", 32'(commit), 0);

    // saturation and simultaneous issue/retire
    bus.xlat_req = 1'b1; tick(8);
    chk("sat_cnt", 32'(cnt), 8);
    chk("sat_rdy", 32'(bus.xlat_req_ready), 0);
    tick();
    chk("sat_hold", 32'(cnt), 8);
    bus.xlat_req = 1'b0; bus.xlat_done = 1'b1; tick(3);
    chk("cnt5", 32'(cnt), 5);
    bus.xlat_req = 1'b1; tick(); bus.xlat_req = 1'b0;
    chk("simul", 32'(cnt), 5);
    tick(5); bus.xlat_done = 1'b0;
    chk("drain0", 32'(cnt), 0);
    chk("no_uflow", 32'(uflow), 0);

    // underflow, sticky
    bus.xlat_done = 1'b1; tick(); bus.xlat_done = 1'b0;
    chk("uflow", 32'(uflow), 1);
    chk("uflow_cnt", 32'(cnt), 0);
    tick(2);
    chk("uflow_sticky", 32'(uflow), 1);

    // debug bypass
    dbg = 1'b1;
    chk("dbg_lat", 32'(en_m), 1);
    tick();
    chk("dbg_en", 32'(en_m), 0);
    chk("dbg_priv", 32'(priv_m), 1);
    dbg = 1'b0; tick();
    chk("undbg_en", 32'(en_m), 1);

    // reset during DRAIN discards the staged write
    bus.xlat_req = 1'b1; tick(); bus.xlat_req = 1'b0;
    wr(2'd0, 1'b0, 1'b0, 1'b1, 5'h1f);
    tick(); bus.cfg_wr_valid = 1'b0;
    chk("rd_drain", 32'(bus.cfg_wr_ready), 0);
    #1 reset = 1'b0;
    #1;
    chk("rd_en",    32'(en_m), 0);
    chk("rd_priv",  32'(priv_m), 1);
    chk("rd_wrrdy", 32'(bus.cfg_wr_ready), 1);
    chk("rd_rqrdy", 32'(bus.xlat_req_ready), 1);
    chk("rd_cnt",   32'(cnt), 0);
    chk("rd_uflow", 32'(uflow), 0);
    tick(); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_nocmt", 32'(commit), 0);
    end
    chk("rd_priv_kept", 32'(priv_m), 1);
    chk("rd_k64_kept",  32'(k64_m), 0);
    chk("rd_smem_kept", 32'(smem_m), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
